scoreboard: RTL and testbench
=============================

SCOREBOARD -- requirements
Module: scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, registers per class (index width 5).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports issue0_valid, issue0_rs1_valid, issue0_rs2_valid, issue0_rd_valid  input  1 each  slot-0 instruction and operand/destination valid flags.
REQ-005 SHALL have ports issue0_rs1_class, issue0_rs2_class, issue0_rd_class  input  2 each  register class (00 scalar, 01 fp, 10 vector, 11 none).
REQ-006 SHALL have ports issue0_rs1, issue0_rs2, issue0_rd  input  5 each  register indices.
REQ-007 SHALL have ports issue0_rs1_fwd, issue0_rs2_fwd  input  1 each  operand covered by bypass, so busy is ignored.
REQ-008 SHALL have port accept0  input  1  slot-0 instruction issued this cycle.
REQ-009 SHALL have port stall0  output  1  slot-0 hazard.
REQ-010 SHALL have an identical slot-1 port set (issue1_*, accept1 input, stall1 output).
REQ-011 SHALL have flush groups flush_rr, flush_rr1, flush_ex1 (each: strobe 1, *_rd_valid 1, *_rd_class 2, *_rd 5), all inputs; each group cancels one in-flight destination.
REQ-012 SHALL have inputs wb_scalar_valid0..2 (1 each) with wb_scalar_rd0..2 (5 each), wb_fp_valid with wb_fp_rd, and wb_vec_valid with wb_vec_rd.
REQ-013 SHALL have port flush_all  input  1  clear every busy bit.

Function
REQ-014 SHALL hold three busy vectors (scalar, fp, vector), NUM_REGS bits each.
REQ-015 stall0 SHALL be combinational: issue0_valid AND (rs1 hazard OR rs2 hazard OR rd WAW hazard).
REQ-016 rsN hazard = rsN_valid AND class != 11 AND busy[class][rsN] AND NOT rsN_fwd.
REQ-017 rd hazard = rd_valid AND class != 11 AND busy[class][rd].
REQ-018 Scalar register 0 SHALL never be busy or cause a hazard.
REQ-019 stall1 SHALL also assert when issue0_valid AND accept0 AND slot-0 rd (valid, same class, non-x0) matches slot-1 rs1, rs2 or rd (non-forwarded).
REQ-020 On accept with rd_valid, class != 11 and not scalar x0, the busy bit SHALL be set at the next edge.
REQ-021 Each writeback valid SHALL clear busy of its rd in its class at the next edge.
REQ-022 Each flush strobe with rd_valid SHALL clear busy[rd_class][rd] at the next edge.
REQ-023 Same edge, same bit: a set from accept SHALL win over a writeback or flush clear.
REQ-024 flush_all SHALL clear all bits and suppress every set in that cycle.
REQ-025 Multiple clears in one cycle SHALL all take effect.

Reset
REQ-026 When rst is high at an edge, all busy bits SHALL become 0; stall0/stall1 then depend only on slot-1 intra-bundle checks, so they are 0 when issue is idle.
REQ-027 Reset SHALL override accept, writeback and flush inputs in the same cycle.

Configuration
REQ-028 Macro SCOREBOARD_DUAL_ISSUE_EN SHALL gate slot 1. When defined: slot 1 behaves per REQ-010/019/020. When undefined: issue1_* and accept1 are ignored and stall1 = issue1_valid.

Structure
REQ-029 The 2-bit register-class typedef and its codes (SCALAR, FP, VEC, NONE) SHALL reside in isa_pkg.
REQ-030 One sub-module, sb_busy_bank (one busy vector with set/clear/lookup), SHALL be instantiated once per class.

Verification
REQ-031 After reset: accept0 with scalar rd=5, then present rd=5 again -> stall0=1.
REQ-032 Scalar rd=5 busy, pulse flush_all, re-present rd=5 -> stall0=0.
REQ-033 Scalar rd=5 busy, wb_scalar_valid1 with rd=5, then issue rs1=5 -> stall0=0.
REQ-034 fp rd=3 busy, issue fp rs2=3 with issue0_rs2_fwd=1 -> stall0=0; with fwd=0 -> stall0=1.
REQ-035 accept0 with rd=x0, then issue rs1=x0 -> stall0=0.
REQ-036 Same cycle: accept0 with scalar rd=7 and slot 1 rs1=7 -> stall1=1; flush_ex1 with vector rd=9 clears busy vector 9.

Source files
------------

// File: rtl/isa_pkg.sv
// Register-class encoding and index sizing shared by the scoreboard and its busy banks.
package isa_pkg;

  typedef enum logic [1:0] {
    SCALAR = 2'b00,
    FP     = 2'b01,
    VEC    = 2'b10,
    NONE   = 2'b11
  } reg_class_e;

  localparam int IDX_W       = 5;
  localparam int NUM_CLASSES = 3;

  // A destination is tracked only if it names a real class and is not the hardwired scalar x0.
  function automatic logic is_tracked(reg_class_e cls, logic [IDX_W-1:0] idx);
    return (cls != NONE) && !((cls == SCALAR) && (idx == '0));
  endfunction

endpackage

// File: rtl/sb_busy_bank.sv
// One busy vector: parallel set/clear ports, a bulk clear and parallel lookups.
// HARD_ZERO pins register 0 idle for classes with a hardwired zero register.
module sb_busy_bank
  import isa_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int NUM_SET   = 2,
  parameter int NUM_CLR   = 4,
  parameter int NUM_LK    = 6,
  parameter bit HARD_ZERO = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_SET-1:0]               set_valid,
  input  logic [NUM_SET-1:0][IDX_W-1:0]    set_idx,
  input  logic [NUM_CLR-1:0]               clr_valid,
  input  logic [NUM_CLR-1:0][IDX_W-1:0]    clr_idx,
  input  logic                             clr_all,
  input  logic [NUM_LK-1:0][IDX_W-1:0]     lk_idx,
  output logic [NUM_LK-1:0]                lk_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  function automatic logic in_range(logic [IDX_W-1:0] idx);
    return 32'(idx) < NUM_REGS;
  endfunction

  // Clears first, sets after, so an issue wins over a retiring writer of the same register.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_CLR; i++) begin
      if (clr_valid[i] && in_range(clr_idx[i])) begin
        busy_d[clr_idx[i]] = 1'b0;
      end
    end
    for (int j = 0; j < NUM_SET; j++) begin
      if (set_valid[j] && in_range(set_idx[j])) begin
        busy_d[set_idx[j]] = 1'b1;
      end
    end
    if (HARD_ZERO) begin
      busy_d[0] = 1'b0;
    end
    if (clr_all) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    lk_busy = '0;
    for (int k = 0; k < NUM_LK; k++) begin
      if (in_range(lk_idx[k]) && !(HARD_ZERO && (lk_idx[k] == '0))) begin
        lk_busy[k] = busy_q[lk_idx[k]];
      end
    end
  end

endmodule

// File: rtl/scoreboard.sv
// Register scoreboard for a two-slot issue stage: busy tracking per class, RAW/WAW stalls.
// SCOREBOARD_DUAL_ISSUE_EN enables slot 1; without it slot 1 simply stalls whenever valid.
module scoreboard
  import isa_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             issue0_valid,
  input  logic             issue0_rs1_valid,
  input  logic             issue0_rs2_valid,
  input  logic             issue0_rd_valid,
  input  logic [1:0]       issue0_rs1_class,
  input  logic [1:0]       issue0_rs2_class,
  input  logic [1:0]       issue0_rd_class,
  input  logic [IDX_W-1:0] issue0_rs1,
  input  logic [IDX_W-1:0] issue0_rs2,
  input  logic [IDX_W-1:0] issue0_rd,
  input  logic             issue0_rs1_fwd,
  input  logic             issue0_rs2_fwd,
  input  logic             accept0,
  output logic             stall0,

  input  logic             issue1_valid,
  input  logic             issue1_rs1_valid,
  input  logic             issue1_rs2_valid,
  input  logic             issue1_rd_valid,
  input  logic [1:0]       issue1_rs1_class,
  input  logic [1:0]       issue1_rs2_class,
  input  logic [1:0]       issue1_rd_class,
  input  logic [IDX_W-1:0] issue1_rs1,
  input  logic [IDX_W-1:0] issue1_rs2,
  input  logic [IDX_W-1:0] issue1_rd,
  input  logic             issue1_rs1_fwd,
  input  logic             issue1_rs2_fwd,
  input  logic             accept1,
  output logic             stall1,

  input  logic             flush_rr,
  input  logic             flush_rr_rd_valid,
  input  logic [1:0]       flush_rr_rd_class,
  input  logic [IDX_W-1:0] flush_rr_rd,
  input  logic             flush_rr1,
  input  logic             flush_rr1_rd_valid,
  input  logic [1:0]       flush_rr1_rd_class,
  input  logic [IDX_W-1:0] flush_rr1_rd,
  input  logic             flush_ex1,
  input  logic             flush_ex1_rd_valid,
  input  logic [1:0]       flush_ex1_rd_class,
  input  logic [IDX_W-1:0] flush_ex1_rd,

  input  logic             wb_scalar_valid0,
  input  logic [IDX_W-1:0] wb_scalar_rd0,
  input  logic             wb_scalar_valid1,
  input  logic [IDX_W-1:0] wb_scalar_rd1,
  input  logic             wb_scalar_valid2,
  input  logic [IDX_W-1:0] wb_scalar_rd2,
  input  logic             wb_fp_valid,
  input  logic [IDX_W-1:0] wb_fp_rd,
  input  logic             wb_vec_valid,
  input  logic [IDX_W-1:0] wb_vec_rd,

  input  logic             flush_all
);

  // Lookup order: slot0 rs1, rs2, rd, then slot1 rs1, rs2, rd.
  logic [5:0][IDX_W-1:0] lk_idx;
  logic [5:0][1:0]       lk_cls;
  logic [5:0]            lk_hit_s, lk_hit_f, lk_hit_v, lk_hit;

  assign lk_idx = {issue1_rd, issue1_rs2, issue1_rs1, issue0_rd, issue0_rs2, issue0_rs1};
  assign lk_cls = {issue1_rd_class, issue1_rs2_class, issue1_rs1_class,
                   issue0_rd_class, issue0_rs2_class, issue0_rs1_class};

  always_comb begin
    lk_hit = '0;
    for (int k = 0; k < 6; k++) begin
      case (reg_class_e'(lk_cls[k]))
        SCALAR:  lk_hit[k] = lk_hit_s[k];
        FP:      lk_hit[k] = lk_hit_f[k];
        VEC:     lk_hit[k] = lk_hit_v[k];
        default: lk_hit[k] = 1'b0;
      endcase
    end
  end

  logic haz0, haz1, intra1;
  logic slot0_rd_tracked, slot1_rd_tracked;

  assign slot0_rd_tracked = issue0_rd_valid && is_tracked(reg_class_e'(issue0_rd_class), issue0_rd);
  assign slot1_rd_tracked = issue1_rd_valid && is_tracked(reg_class_e'(issue1_rd_class), issue1_rd);

  assign haz0 = (issue0_rs1_valid && lk_hit[0] && !issue0_rs1_fwd) ||
                (issue0_rs2_valid && lk_hit[1] && !issue0_rs2_fwd) ||
                (issue0_rd_valid  && lk_hit[2]);

  assign haz1 = (issue1_rs1_valid && lk_hit[3] && !issue1_rs1_fwd) ||
                (issue1_rs2_valid && lk_hit[4] && !issue1_rs2_fwd) ||
                (issue1_rd_valid  && lk_hit[5]);

  // Slot 1 cannot see slot 0's destination in the busy vectors until next cycle.
  assign intra1 = issue0_valid && accept0 && slot0_rd_tracked && (
                  (issue1_rs1_valid && !issue1_rs1_fwd &&
                   (issue1_rs1_class == issue0_rd_class) && (issue1_rs1 == issue0_rd)) ||
                  (issue1_rs2_valid && !issue1_rs2_fwd &&
                   (issue1_rs2_class == issue0_rd_class) && (issue1_rs2 == issue0_rd)) ||
                  (issue1_rd_valid &&
                   (issue1_rd_class == issue0_rd_class) && (issue1_rd == issue0_rd)));

  assign stall0 = issue0_valid && haz0;

  logic [1:0]            set_req;
  logic [1:0][1:0]       set_cls;
  logic [1:0][IDX_W-1:0] set_idx;

  assign set_req[0] = accept0 && slot0_rd_tracked;
  assign set_cls    = {issue1_rd_class, issue0_rd_class};
  assign set_idx    = {issue1_rd, issue0_rd};

`ifdef SCOREBOARD_DUAL_ISSUE_EN
  assign set_req[1] = accept1 && slot1_rd_tracked;
  assign stall1     = issue1_valid && (haz1 || intra1);
`else
  logic unused_slot1;
  assign set_req[1]   = 1'b0;
  assign stall1       = issue1_valid;
  assign unused_slot1 = ^{accept1, slot1_rd_tracked, haz1, intra1};
`endif

  logic [1:0] set_s, set_f, set_v;

  always_comb begin
    set_s = '0;
    set_f = '0;
    set_v = '0;
    for (int j = 0; j < 2; j++) begin
      set_s[j] = set_req[j] && (set_cls[j] == SCALAR);
      set_f[j] = set_req[j] && (set_cls[j] == FP);
      set_v[j] = set_req[j] && (set_cls[j] == VEC);
    end
  end

  logic [2:0]            fl_v;
  logic [2:0][1:0]       fl_cls;
  logic [2:0][IDX_W-1:0] fl_idx;
  logic [2:0]            fl_s, fl_f, fl_v_vec;

  assign fl_v   = {flush_ex1 && flush_ex1_rd_valid,
                   flush_rr1 && flush_rr1_rd_valid,
                   flush_rr  && flush_rr_rd_valid};
  assign fl_cls = {flush_ex1_rd_class, flush_rr1_rd_class, flush_rr_rd_class};
  assign fl_idx = {flush_ex1_rd, flush_rr1_rd, flush_rr_rd};

  always_comb begin
    fl_s     = '0;
    fl_f     = '0;
    fl_v_vec = '0;
    for (int g = 0; g < 3; g++) begin
      fl_s[g]     = fl_v[g] && (fl_cls[g] == SCALAR);
      fl_f[g]     = fl_v[g] && (fl_cls[g] == FP);
      fl_v_vec[g] = fl_v[g] && (fl_cls[g] == VEC);
    end
  end

  sb_busy_bank #(
    .NUM_REGS (NUM_REGS),
    .NUM_SET  (2),
    .NUM_CLR  (6),
    .NUM_LK   (6),
    .HARD_ZERO(1'b1)
  ) u_bank_scalar (
    .clk      (clk),
    .rst      (rst),
    .set_valid(set_s),
    .set_idx  (set_idx),
    .clr_valid({fl_s, wb_scalar_valid2, wb_scalar_valid1, wb_scalar_valid0}),
    .clr_idx  ({fl_idx, wb_scalar_rd2, wb_scalar_rd1, wb_scalar_rd0}),
    .clr_all  (flush_all),
    .lk_idx   (lk_idx),
    .lk_busy  (lk_hit_s)
  );

  sb_busy_bank #(
    .NUM_REGS (NUM_REGS),
    .NUM_SET  (2),
    .NUM_CLR  (4),
    .NUM_LK   (6),
    .HARD_ZERO(1'b0)
  ) u_bank_fp (
    .clk      (clk),
    .rst      (rst),
    .set_valid(set_f),
    .set_idx  (set_idx),
    .clr_valid({fl_f, wb_fp_valid}),
    .clr_idx  ({fl_idx, wb_fp_rd}),
    .clr_all  (flush_all),
    .lk_idx   (lk_idx),
    .lk_busy  (lk_hit_f)
  );

  sb_busy_bank #(
    .NUM_REGS (NUM_REGS),
    .NUM_SET  (2),
    .NUM_CLR  (4),
    .NUM_LK   (6),
    .HARD_ZERO(1'b0)
  ) u_bank_vec (
    .clk      (clk),
    .rst      (rst),
    .set_valid(set_v),
    .set_idx  (set_idx),
    .clr_valid({fl_v_vec, wb_vec_valid}),
    .clr_idx  ({fl_idx, wb_vec_rd}),
    .clr_all  (flush_all),
    .lk_idx   (lk_idx),
    .lk_busy  (lk_hit_v)
  );

endmodule

// File: tb/tb_scoreboard.sv
// Scoreboard bench: directed scenarios plus randomized traffic against a busy-table model.
module tb_scoreboard;

  logic clk = 1'b0;
  logic rst;
  logic       issue0_valid, issue0_rs1_valid, issue0_rs2_valid, issue0_rd_valid;
  logic [1:0] issue0_rs1_class, issue0_rs2_class, issue0_rd_class;
  logic [4:0] issue0_rs1, issue0_rs2, issue0_rd;
  logic       issue0_rs1_fwd, issue0_rs2_fwd, accept0, stall0;
  logic       issue1_valid, issue1_rs1_valid, issue1_rs2_valid, issue1_rd_valid;
  logic [1:0] issue1_rs1_class, issue1_rs2_class, issue1_rd_class;
  logic [4:0] issue1_rs1, issue1_rs2, issue1_rd;
  logic       issue1_rs1_fwd, issue1_rs2_fwd, accept1, stall1;
  logic       flush_rr, flush_rr_rd_valid, flush_rr1, flush_rr1_rd_valid, flush_ex1, flush_ex1_rd_valid;
  logic [1:0] flush_rr_rd_class, flush_rr1_rd_class, flush_ex1_rd_class;
  logic [4:0] flush_rr_rd, flush_rr1_rd, flush_ex1_rd;
  logic       wb_scalar_valid0, wb_scalar_valid1, wb_scalar_valid2, wb_fp_valid, wb_vec_valid;
  logic [4:0] wb_scalar_rd0, wb_scalar_rd1, wb_scalar_rd2, wb_fp_rd, wb_vec_rd;
  logic       flush_all;

  int total = 0;
  int bad   = 0;

  // Reference busy table: [class][register], class 0 scalar, 1 fp, 2 vector.
  bit mb [3][32];

  always #5 clk = ~clk;

  scoreboard #(.NUM_REGS(32)) dut (
    .clk(clk), .rst(rst),
    .issue0_valid(issue0_valid), .issue0_rs1_valid(issue0_rs1_valid),
    .issue0_rs2_valid(issue0_rs2_valid), .issue0_rd_valid(issue0_rd_valid),
    .issue0_rs1_class(issue0_rs1_class), .issue0_rs2_class(issue0_rs2_class),
    .issue0_rd_class(issue0_rd_class), .issue0_rs1(issue0_rs1), .issue0_rs2(issue0_rs2),
    .issue0_rd(issue0_rd), .issue0_rs1_fwd(issue0_rs1_fwd), .issue0_rs2_fwd(issue0_rs2_fwd),
    .accept0(accept0), .stall0(stall0),
    .issue1_valid(issue1_valid), .issue1_rs1_valid(issue1_rs1_valid),
    .issue1_rs2_valid(issue1_rs2_valid), .issue1_rd_valid(issue1_rd_valid),
    .issue1_rs1_class(issue1_rs1_class), .issue1_rs2_class(issue1_rs2_class),
    .issue1_rd_class(issue1_rd_class), .issue1_rs1(issue1_rs1), .issue1_rs2(issue1_rs2),
    .issue1_rd(issue1_rd), .issue1_rs1_fwd(issue1_rs1_fwd), .issue1_rs2_fwd(issue1_rs2_fwd),
    .accept1(accept1), .stall1(stall1),
    .flush_rr(flush_rr), .flush_rr_rd_valid(flush_rr_rd_valid),
    .flush_rr_rd_class(flush_rr_rd_class), .flush_rr_rd(flush_rr_rd),
    .flush_rr1(flush_rr1), .flush_rr1_rd_valid(flush_rr1_rd_valid),
    .flush_rr1_rd_class(flush_rr1_rd_class), .flush_rr1_rd(flush_rr1_rd),
    .flush_ex1(flush_ex1), .flush_ex1_rd_valid(flush_ex1_rd_valid),
    .flush_ex1_rd_class(flush_ex1_rd_class), .flush_ex1_rd(flush_ex1_rd),
    .wb_scalar_valid0(wb_scalar_valid0), .wb_scalar_rd0(wb_scalar_rd0),
    .wb_scalar_valid1(wb_scalar_valid1), .wb_scalar_rd1(wb_scalar_rd1),
    .wb_scalar_valid2(wb_scalar_valid2), .wb_scalar_rd2(wb_scalar_rd2),
    .wb_fp_valid(wb_fp_valid), .wb_fp_rd(wb_fp_rd),
    .wb_vec_valid(wb_vec_valid), .wb_vec_rd(wb_vec_rd),
    .flush_all(flush_all)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_busy(input int cls, input int idx);
    if (cls == 3) return 1'b0;
    return mb[cls][idx];
  endfunction

  function automatic bit m_tracked(input int cls, input int idx);
    return (cls != 3) && !(cls == 0 && idx == 0);
  endfunction

  function automatic bit exp_stall0();
    bit h;
    h = (issue0_rs1_valid && m_busy(issue0_rs1_class, issue0_rs1) && !issue0_rs1_fwd) ||
        (issue0_rs2_valid && m_busy(issue0_rs2_class, issue0_rs2) && !issue0_rs2_fwd) ||
        (issue0_rd_valid  && m_busy(issue0_rd_class,  issue0_rd));
    return issue0_valid && h;
  endfunction

  function automatic bit exp_stall1();
`ifdef SCOREBOARD_DUAL_ISSUE_EN
    bit h, intra;
    h = (issue1_rs1_valid && m_busy(issue1_rs1_class, issue1_rs1) && !issue1_rs1_fwd) ||
        (issue1_rs2_valid && m_busy(issue1_rs2_class, issue1_rs2) && !issue1_rs2_fwd) ||
        (issue1_rd_valid  && m_busy(issue1_rd_class,  issue1_rd));
    intra = 1'b0;
    if (issue0_valid && accept0 && issue0_rd_valid && m_tracked(issue0_rd_class, issue0_rd)) begin
      if (issue1_rs1_valid && !issue1_rs1_fwd && issue1_rs1_class == issue0_rd_class && issue1_rs1 == issue0_rd) intra = 1'b1;
      if (issue1_rs2_valid && !issue1_rs2_fwd && issue1_rs2_class == issue0_rd_class && issue1_rs2 == issue0_rd) intra = 1'b1;
      if (issue1_rd_valid && issue1_rd_class == issue0_rd_class && issue1_rd == issue0_rd) intra = 1'b1;
    end
    return issue1_valid && (h || intra);
`else
    return issue1_valid;
`endif
  endfunction

  function automatic void m_clear(input bit v, input int cls, input int idx);
    if (v && cls != 3) mb[cls][idx] = 1'b0;
  endfunction

  // Next-state of the busy table from this cycle's inputs: clears, then sets (sets win), then global flush.
  function automatic void m_edge();
    if (rst) begin
      foreach (mb[c, r]) mb[c][r] = 1'b0;
      return;
    end
    m_clear(wb_scalar_valid0, 0, wb_scalar_rd0);
    m_clear(wb_scalar_valid1, 0, wb_scalar_rd1);
    m_clear(wb_scalar_valid2, 0, wb_scalar_rd2);
    m_clear(wb_fp_valid, 1, wb_fp_rd);
    m_clear(wb_vec_valid, 2, wb_vec_rd);
    m_clear(flush_rr  && flush_rr_rd_valid,  flush_rr_rd_class,  flush_rr_rd);
    m_clear(flush_rr1 && flush_rr1_rd_valid, flush_rr1_rd_class, flush_rr1_rd);
    m_clear(flush_ex1 && flush_ex1_rd_valid, flush_ex1_rd_class, flush_ex1_rd);
    if (flush_all) begin
      foreach (mb[c, r]) mb[c][r] = 1'b0;
      return;
    end
    if (accept0 && issue0_rd_valid && m_tracked(issue0_rd_class, issue0_rd))
      mb[issue0_rd_class][issue0_rd] = 1'b1;
`ifdef SCOREBOARD_DUAL_ISSUE_EN
    if (accept1 && issue1_rd_valid && m_tracked(issue1_rd_class, issue1_rd))
      mb[issue1_rd_class][issue1_rd] = 1'b1;
`endif
  endfunction

  // Called just after inputs change on the falling edge; returns on the next falling edge.
  task automatic tick();
    #1;
    check("stall0", {31'b0, stall0}, {31'b0, exp_stall0()});
    check("stall1", {31'b0, stall1}, {31'b0, exp_stall1()});
    m_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; flush_all = 0; accept0 = 0; accept1 = 0;
    {issue0_valid, issue0_rs1_valid, issue0_rs2_valid, issue0_rd_valid, issue0_rs1_fwd, issue0_rs2_fwd} = '0;
    {issue0_rs1_class, issue0_rs2_class, issue0_rd_class, issue0_rs1, issue0_rs2, issue0_rd} = '0;
    {issue1_valid, issue1_rs1_valid, issue1_rs2_valid, issue1_rd_valid, issue1_rs1_fwd, issue1_rs2_fwd} = '0;
    {issue1_rs1_class, issue1_rs2_class, issue1_rd_class, issue1_rs1, issue1_rs2, issue1_rd} = '0;
    {flush_rr, flush_rr_rd_valid, flush_rr_rd_class, flush_rr_rd} = '0;
    {flush_rr1, flush_rr1_rd_valid, flush_rr1_rd_class, flush_rr1_rd} = '0;
    {flush_ex1, flush_ex1_rd_valid, flush_ex1_rd_class, flush_ex1_rd} = '0;
    {wb_scalar_valid0, wb_scalar_rd0, wb_scalar_valid1, wb_scalar_rd1, wb_scalar_valid2, wb_scalar_rd2} = '0;
    {wb_fp_valid, wb_fp_rd, wb_vec_valid, wb_vec_rd} = '0;
  endtask

  task automatic issue_rd(input logic [1:0] cls, input logic [4:0] idx, input logic acc);
    idle();
    issue0_valid = 1; issue0_rd_valid = 1; issue0_rd_class = cls; issue0_rd = idx; accept0 = acc;
  endtask

  task automatic issue_rs1(input logic [1:0] cls, input logic [4:0] idx);
    idle();
    issue0_valid = 1; issue0_rs1_valid = 1; issue0_rs1_class = cls; issue0_rs1 = idx;
  endtask

  function automatic logic [4:0] rnd_idx();
    if ($urandom_range(0, 9) < 7) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  function automatic logic [1:0] rnd_cls();
    return 2'($urandom_range(0, 3));
  endfunction

  task automatic randomize_inputs();
    rst       = ($urandom_range(0, 99) == 0);
    flush_all = ($urandom_range(0, 39) == 0);
    issue0_valid = 1'($urandom); issue0_rs1_valid = 1'($urandom); issue0_rs2_valid = 1'($urandom);
    issue0_rd_valid = 1'($urandom); issue0_rs1_fwd = ($urandom_range(0, 3) == 0);
    issue0_rs2_fwd = ($urandom_range(0, 3) == 0); accept0 = 1'($urandom);
    issue0_rs1_class = rnd_cls(); issue0_rs2_class = rnd_cls(); issue0_rd_class = rnd_cls();
    issue0_rs1 = rnd_idx(); issue0_rs2 = rnd_idx(); issue0_rd = rnd_idx();
    issue1_valid = 1'($urandom); issue1_rs1_valid = 1'($urandom); issue1_rs2_valid = 1'($urandom);
    issue1_rd_valid = 1'($urandom); issue1_rs1_fwd = ($urandom_range(0, 3) == 0);
    issue1_rs2_fwd = ($urandom_range(0, 3) == 0); accept1 = 1'($urandom);
    issue1_rs1_class = rnd_cls(); issue1_rs2_class = rnd_cls(); issue1_rd_class = rnd_cls();
    issue1_rs1 = rnd_idx(); issue1_rs2 = rnd_idx(); issue1_rd = rnd_idx();
    flush_rr  = ($urandom_range(0, 5) == 0); flush_rr_rd_valid  = 1'($urandom);
    flush_rr_rd_class  = rnd_cls(); flush_rr_rd  = rnd_idx();
    flush_rr1 = ($urandom_range(0, 5) == 0); flush_rr1_rd_valid = 1'($urandom);
    flush_rr1_rd_class = rnd_cls(); flush_rr1_rd = rnd_idx();
    flush_ex1 = ($urandom_range(0, 5) == 0); flush_ex1_rd_valid = 1'($urandom);
    flush_ex1_rd_class = rnd_cls(); flush_ex1_rd = rnd_idx();
    wb_scalar_valid0 = ($urandom_range(0, 2) == 0); wb_scalar_rd0 = rnd_idx();
    wb_scalar_valid1 = ($urandom_range(0, 2) == 0); wb_scalar_rd1 = rnd_idx();
    wb_scalar_valid2 = ($urandom_range(0, 2) == 0); wb_scalar_rd2 = rnd_idx();
    wb_fp_valid  = ($urandom_range(0, 2) == 0); wb_fp_rd  = rnd_idx();
    wb_vec_valid = ($urandom_range(0, 2) == 0); wb_vec_rd = rnd_idx();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (mb[c, r]) mb[c][r] = 1'b0;
    idle();
    @(negedge clk);
    rst = 1;
    tick();

    // Reset state: nothing busy, so a scalar rd=5 probe does not stall
    issue_rd(2'b00, 5'd5, 1'b1);
    #1 check("reset_rd5_idle", {31'b0, stall0}, 32'd0);
    tick();
    issue_rd(2'b00, 5'd5, 1'b0);
    #1 check("waw_rd5", {31'b0, stall0}, 32'd1);
    tick();

    idle(); flush_all = 1;
    tick();
    issue_rd(2'b00, 5'd5, 1'b0);
    #1 check("flush_all_rd5", {31'b0, stall0}, 32'd0);
    tick();

    issue_rd(2'b00, 5'd5, 1'b1);
    tick();
    idle(); wb_scalar_valid1 = 1; wb_scalar_rd1 = 5'd5;
    tick();
    issue_rs1(2'b00, 5'd5);
    #1 check("wb1_clears_rs1", {31'b0, stall0}, 32'd0);
    tick();

    issue_rd(2'b01, 5'd3, 1'b1);
    tick();
    idle(); issue0_valid = 1; issue0_rs2_valid = 1; issue0_rs2_class = 2'b01; issue0_rs2 = 5'd3; issue0_rs2_fwd = 1;
    #1 check("fp_rs2_fwd", {31'b0, stall0}, 32'd0);
    issue0_rs2_fwd = 0;
    #1 check("fp_rs2_nofwd", {31'b0, stall0}, 32'd1);
    tick();

    issue_rd(2'b00, 5'd0, 1'b1);
    tick();
    issue_rs1(2'b00, 5'd0);
    #1 check("x0_rs1", {31'b0, stall0}, 32'd0);
    issue0_rd_valid = 1; issue0_rd_class = 2'b00; issue0_rd = 5'd0;
    #1 check("x0_rd", {31'b0, stall0}, 32'd0);
    tick();

    issue_rd(2'b10, 5'd9, 1'b1);
    tick();
    issue_rs1(2'b10, 5'd9);
    #1 check("vec9_busy", {31'b0, stall0}, 32'd1);
    tick();
    issue_rd(2'b00, 5'd7, 1'b1);
    issue1_valid = 1; issue1_rs1_valid = 1; issue1_rs1_class = 2'b00; issue1_rs1 = 5'd7;
    flush_ex1 = 1; flush_ex1_rd_valid = 1; flush_ex1_rd_class = 2'b10; flush_ex1_rd = 5'd9;
    #1 check("intra_bundle_rs1", {31'b0, stall1}, 32'd1);
    tick();
    issue_rs1(2'b10, 5'd9);
    #1 check("flush_ex1_vec9", {31'b0, stall0}, 32'd0);
    tick();
    issue_rs1(2'b00, 5'd7);
    #1 check("scalar7_busy", {31'b0, stall0}, 32'd1);
    tick();

    // Set and writeback of the same register in one cycle: the set wins
    issue_rd(2'b00, 5'd6, 1'b1); wb_scalar_valid0 = 1; wb_scalar_rd0 = 5'd6;
    tick();
    issue_rs1(2'b00, 5'd6);
    #1 check("set_beats_wb", {31'b0, stall0}, 32'd1);
    tick();

    // Reset beats a same-cycle accept
    issue_rd(2'b01, 5'd10, 1'b1); rst = 1;
    tick();
    idle(); issue0_valid = 1; issue0_rs1_valid = 1; issue0_rs1_class = 2'b01; issue0_rs1 = 5'd10;
    issue0_rs2_valid = 1; issue0_rs2_class = 2'b00; issue0_rs2 = 5'd6;
    #1 check("rst_beats_accept", {31'b0, stall0}, 32'd0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      tick();
    end

    idle();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
